// File: rtl/ro_port_scheduler_pkg.sv
// Shared read-only interconnect definitions: scheduler FSM states and sizing helpers.
// The state enum is reused by the write-side scheduler.
package ro_port_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam int MAX_READ_LATENCY = 4;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_port_scheduler_if.sv
// Master-side request/response bundle plus the slave memory port of one read scheduler.
// The scheduler uses the slave modport; the request decode and memory use the master modport.
interface ro_port_scheduler_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic [NUM_PORTS-1:0]            master_data_req_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] master_data_addr_i;
  logic [NUM_PORTS-1:0]            master_data_gnt_o;
  logic [NUM_PORTS-1:0]            master_data_rvalid_o;
  logic [NUM_PORTS*DATA_WIDTH-1:0] master_data_rdata_o;
  logic                            slave_data_req_o;
  logic [ADDR_WIDTH-1:0]           slave_data_addr_o;
  logic                            slave_data_gnt_i;
  logic [DATA_WIDTH-1:0]           slave_data_rdata_i;

  modport master (
    output master_data_req_i, master_data_addr_i, slave_data_gnt_i, slave_data_rdata_i,
    input  master_data_gnt_o, master_data_rvalid_o, master_data_rdata_o,
           slave_data_req_o, slave_data_addr_o
  );

  modport slave (
    input  master_data_req_i, master_data_addr_i, slave_data_gnt_i, slave_data_rdata_i,
    output master_data_gnt_o, master_data_rvalid_o, master_data_rdata_o,
           slave_data_req_o, slave_data_addr_o
  );

endinterface

// File: rtl/ro_port_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from rr_ptr+1 with wrap.
module ro_port_scheduler_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 found
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any branch;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_port_scheduler.sv
// Per-slave read-port scheduler: round-robin ownership of one slave read port, held from
// the address handshake until the fixed-latency read data is returned to the owner.
module ro_port_scheduler
  import ro_port_scheduler_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ro_port_scheduler_if.slave   bus,
  output logic [NUM_PORTS-1:0] owner_o,
  output logic                 busy_o
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int LAT_W = idx_width(MAX_READ_LATENCY);

  sched_state_e         state_q, state_d;
  logic [NUM_PORTS-1:0] owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;

  logic [IDX_W-1:0]      owner_idx;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic                  owner_req;
  logic [NUM_PORTS-1:0]  pick_grant;
  logic                  pick_found;

  ro_port_scheduler_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_rr_pick (
    .req   (bus.master_data_req_i),
    .rr_ptr(rr_ptr_q),
    .grant (pick_grant),
    .found (pick_found)
  );

  // Owner index and address are decoded from the one-hot owner; both are 0 when idle.
  always_comb begin
    owner_idx  = '0;
    owner_addr = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (owner_q[k]) begin
        owner_idx  = IDX_W'(k);
        owner_addr = bus.master_data_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign owner_req = |(bus.master_data_req_i & owner_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    lat_cnt_d = lat_cnt_q;

    bus.master_data_gnt_o    = '0;
    bus.master_data_rvalid_o = '0;
    bus.master_data_rdata_o  = '0;
    bus.slave_data_req_o     = 1'b0;
    bus.slave_data_addr_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_grant;
          state_d = ADDR;
        end
      end

      ADDR: begin
        bus.slave_data_req_o  = owner_req;
        bus.slave_data_addr_o = owner_addr;
        bus.master_data_gnt_o = owner_q & {NUM_PORTS{bus.slave_data_gnt_i & owner_req}};
        if (owner_req && bus.slave_data_gnt_i) begin
          rr_ptr_d  = owner_idx;
          lat_cnt_d = LAT_W'(READ_LATENCY - 1);
          state_d   = RESP;
        end else if (!owner_req) begin
          // Withdrawn before the slave accepted: no transaction, fairness pointer untouched.
          owner_d = '0;
          state_d = IDLE;
        end
      end

      RESP: begin
        bus.slave_data_addr_o = owner_addr;
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          bus.master_data_rvalid_o = owner_q;
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (owner_q[k]) begin
              bus.master_data_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = bus.slave_data_rdata_i;
            end
          end
          // Re-arbitrate in the data cycle so back-to-back transfers skip IDLE.
          if (pick_found) begin
            owner_d = pick_grant;
            state_d = ADDR;
          end else begin
            owner_d = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        owner_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= IDX_W'(NUM_PORTS - 1);
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_ro_port_scheduler.sv
// Directed bench for ro_port_scheduler: READ_LATENCY=1 and READ_LATENCY=3 instances,
// read responses checked by queue-based scoreboards, control outputs checked per cycle.
module tb_ro_port_scheduler;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1;
  exp_t e3;

  logic [NP-1:0] owner1, owner3;
  logic          busy1, busy3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_port_scheduler_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  ro_port_scheduler_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  ro_port_scheduler #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus1),
    .owner_o(owner1),
    .busy_o (busy1)
  );

  ro_port_scheduler #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)
  ) u_dut3 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus3),
    .owner_o(owner3),
    .busy_o (busy3)
  );

  // Slave memory contents as seen at whatever address the scheduler presents.
  function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
    return (a == 10'h05A) ? 32'hDEADBEEF : {16'hA5C3, 6'd0, a};
  endfunction

  assign bus1.slave_data_rdata_i = mem_f(bus1.slave_data_addr_o);
  assign bus3.slave_data_rdata_i = mem_f(bus3.slave_data_addr_o);

  function automatic logic [NP*DW-1:0] rdata_vec(input int port, input logic [31:0] data);
    logic [NP*DW-1:0] v;
    v = '0;
    v[port*DW +: DW] = data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Response monitors: every rvalid must match the oldest expected response exactly.
  always @(negedge clk) begin
    if (bus1.master_data_rvalid_o != '0) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_rvalid", 64'(bus1.master_data_rvalid_o), 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_rvalid_port", 64'(bus1.master_data_rvalid_o), 64'(1) << e1.port);
        check("dut1_rdata", 64'(bus1.master_data_rdata_o), 64'(rdata_vec(e1.port, e1.data)));
        check("dut1_rvalid_cycle", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.master_data_rvalid_o != '0) begin
      if (q3.size() == 0) begin
        check("dut3_unexpected_rvalid", 64'(bus3.master_data_rvalid_o), 64'd0);
      end else begin
        e3 = q3.pop_front();
        check("dut3_rvalid_port", 64'(bus3.master_data_rvalid_o), 64'(1) << e3.port);
        check("dut3_rdata", 64'(bus3.master_data_rdata_o), 64'(rdata_vec(e3.port, e3.data)));
        check("dut3_rvalid_cycle", 64'(cyc), 64'(e3.cyc));
      end
    end
  end

  task automatic push1(input int port, input logic [31:0] data, input int at);
    exp_t e;
    e.port = port; e.data = data; e.cyc = at;
    q1.push_back(e);
  endtask

  task automatic push3(input int port, input logic [31:0] data, input int at);
    exp_t e;
    e.port = port; e.data = data; e.cyc = at;
    q3.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus1.master_data_req_i  = '0;
    bus1.master_data_addr_i = '0;
    bus1.slave_data_gnt_i   = 1'b0;
    bus3.master_data_req_i  = '0;
    bus3.master_data_addr_i = '0;
    bus3.slave_data_gnt_i   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    settle();
    bus1.master_data_req_i = 2'b11;
    #1;
    check("rst_owner", 64'(owner1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_slave_req", 64'(bus1.slave_data_req_o), 64'd0);
    check("rst_gnt", 64'(bus1.master_data_gnt_o), 64'd0);
    check("rst_rvalid", 64'(bus1.master_data_rvalid_o), 64'd0);
    next();
    reset = 1'b1;
    bus1.master_data_req_i = 2'b00;

    // Single request from master 1.
    bus1.master_data_req_i  = 2'b10;
    bus1.master_data_addr_i = {10'h05A, 10'h000};
    bus1.slave_data_gnt_i   = 1'b1;
    settle();
    check("single_idle_busy", 64'(busy1), 64'd0);
    next();
    settle();
    check("single_slave_req", 64'(bus1.slave_data_req_o), 64'd1);
    check("single_slave_addr", 64'(bus1.slave_data_addr_o), 64'h05A);
    check("single_gnt", 64'(bus1.master_data_gnt_o), 64'b10);
    check("single_owner", 64'(owner1), 64'b10);
    push1(1, 32'hDEADBEEF, cyc + 1);
    next();
    bus1.master_data_req_i = 2'b00;
    settle();
    check("single_resp_slave_req", 64'(bus1.slave_data_req_o), 64'd0);
    check("single_resp_addr_held", 64'(bus1.slave_data_addr_o), 64'h05A);
    next();
    settle();
    check("single_back_idle", 64'(busy1), 64'd0);
    check("single_owner_cleared", 64'(owner1), 64'd0);
    next();

    // Contention: both masters continuously, ownership alternates 0,1,0,1 with no IDLE gap.
    bus1.master_data_req_i  = 2'b11;
    bus1.master_data_addr_i = {10'h122, 10'h011};
    settle();
    next();
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("cont_owner_%0d", i), 64'(owner1), 64'(1) << (i % 2));
      check($sformatf("cont_gnt_%0d", i), 64'(bus1.master_data_gnt_o), 64'(1) << (i % 2));
      check($sformatf("cont_addr_%0d", i), 64'(bus1.slave_data_addr_o),
            (i % 2 == 0) ? 64'h011 : 64'h122);
      push1(i % 2, (i % 2 == 0) ? 32'hA5C30011 : 32'hA5C30122, cyc + 1);
      next();
      if (i == 3) bus1.master_data_req_i = 2'b00;
      settle();
      check($sformatf("cont_resp_busy_%0d", i), 64'(busy1), 64'd1);
      check($sformatf("cont_resp_slave_req_%0d", i), 64'(bus1.slave_data_req_o), 64'd0);
      next();
    end
    settle();
    check("cont_back_idle", 64'(busy1), 64'd0);
    next();

    // Slave stall: gnt low for three ADDR cycles, accepted on the fourth.
    bus1.master_data_req_i  = 2'b10;
    bus1.master_data_addr_i = {10'h2A5, 10'h011};
    bus1.slave_data_gnt_i   = 1'b0;
    settle();
    next();
    for (int s = 0; s < 4; s++) begin
      if (s == 3) bus1.slave_data_gnt_i = 1'b1;
      settle();
      check($sformatf("stall_busy_%0d", s), 64'(busy1), 64'd1);
      check($sformatf("stall_slave_req_%0d", s), 64'(bus1.slave_data_req_o), 64'd1);
      check($sformatf("stall_addr_%0d", s), 64'(bus1.slave_data_addr_o), 64'h2A5);
      check($sformatf("stall_gnt_%0d", s), 64'(bus1.master_data_gnt_o),
            (s == 3) ? 64'b10 : 64'b00);
      if (s == 3) push1(1, 32'hA5C302A5, cyc + 1);
      next();
    end
    bus1.master_data_req_i = 2'b00;
    settle();
    next();
    settle();
    check("stall_back_idle", 64'(busy1), 64'd0);
    next();

    // Withdrawn request: master 0 drops req in its first ADDR cycle, rr_ptr stays put.
    bus1.master_data_req_i = 2'b01;
    bus1.slave_data_gnt_i  = 1'b0;
    settle();
    next();
    bus1.master_data_req_i = 2'b00;
    settle();
    check("wd_owner", 64'(owner1), 64'b01);
    check("wd_slave_req", 64'(bus1.slave_data_req_o), 64'd0);
    check("wd_gnt", 64'(bus1.master_data_gnt_o), 64'd0);
    next();
    bus1.master_data_req_i = 2'b11;
    bus1.slave_data_gnt_i  = 1'b1;
    settle();
    check("wd_idle", 64'(busy1), 64'd0);
    check("wd_owner_cleared", 64'(owner1), 64'd0);
    next();
    settle();
    check("wd_regrant_port0", 64'(owner1), 64'b01);
    check("wd_regrant_gnt", 64'(bus1.master_data_gnt_o), 64'b01);
    push1(0, 32'hA5C30011, cyc + 1);
    next();
    bus1.master_data_req_i = 2'b00;
    settle();
    next();

    // Reset one cycle after the handshake: response dropped, rr_ptr back to NUM_PORTS-1.
    bus1.master_data_req_i  = 2'b01;
    bus1.master_data_addr_i = {10'h122, 10'h0F0};
    settle();
    next();
    settle();
    check("rstmid_owner", 64'(owner1), 64'b01);
    check("rstmid_gnt", 64'(bus1.master_data_gnt_o), 64'b01);
    next();
    reset = 1'b0;
    bus1.master_data_req_i = 2'b00;
    settle();
    check("rstmid_busy", 64'(busy1), 64'd0);
    check("rstmid_owner_zero", 64'(owner1), 64'd0);
    check("rstmid_rvalid", 64'(bus1.master_data_rvalid_o), 64'd0);
    check("rstmid_rdata", 64'(bus1.master_data_rdata_o), 64'd0);
    check("rstmid_slave_addr", 64'(bus1.slave_data_addr_o), 64'd0);
    next();
    reset = 1'b1;
    bus1.master_data_req_i = 2'b11;
    settle();
    next();
    settle();
    check("rstmid_first_grant_port0", 64'(owner1), 64'b01);
    push1(0, 32'hA5C300F0, cyc + 1);
    next();
    bus1.master_data_req_i = 2'b00;
    settle();
    next();
    settle();
    next();

    // READ_LATENCY=3: rvalid exactly three cycles after the handshake.
    bus3.master_data_req_i  = 2'b10;
    bus3.master_data_addr_i = {10'h3C3, 10'h000};
    bus3.slave_data_gnt_i   = 1'b1;
    settle();
    next();
    settle();
    check("lat3_gnt", 64'(bus3.master_data_gnt_o), 64'b10);
    check("lat3_slave_req", 64'(bus3.slave_data_req_o), 64'd1);
    push3(1, 32'hA5C303C3, cyc + 3);
    next();
    bus3.master_data_req_i = 2'b00;
    for (int r = 1; r <= 3; r++) begin
      settle();
      check($sformatf("lat3_resp_slave_req_%0d", r), 64'(bus3.slave_data_req_o), 64'd0);
      check($sformatf("lat3_resp_busy_%0d", r), 64'(busy3), 64'd1);
      next();
    end
    settle();
    check("lat3_back_idle", 64'(busy3), 64'd0);
    next();

    repeat (3) next();
    check("dut1_queue_drained", 64'(q1.size()), 64'd0);
    check("dut3_queue_drained", 64'(q3.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ro_port_scheduler.md
Name: ro_port_scheduler

Overview:
- Per-slave read-port scheduler for the read-only interconnect. Shares one slave read port between NUM_PORTS masters using round-robin arbitration.
- Holds ownership from the address handshake until the slave's read data returns after a fixed READ_LATENCY, so rdata and rvalid reach the correct master.
- One instance per slave port, between the master-side request decode and the slave memory port.

Parameters:
- NUM_PORTS, 2, number of requesting masters (>=2)
- DATA_WIDTH, 32, read data width
- ADDR_WIDTH, 10, slave-local address width
- READ_LATENCY, 1, cycles from slave handshake to valid slave_data_rdata_i (legal 1..4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- master_data_req_i  in  NUM_PORTS  per-master read request (already decoded for this slave)
- master_data_addr_i  in  NUM_PORTS*ADDR_WIDTH  per-master address; master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- master_data_gnt_o  out  NUM_PORTS  address-phase grant to master
- master_data_rvalid_o  out  NUM_PORTS  read data valid to master
- master_data_rdata_o  out  NUM_PORTS*DATA_WIDTH  read data to master
- slave_data_req_o  out  1  request to slave
- slave_data_addr_o  out  ADDR_WIDTH  address to slave
- slave_data_gnt_i  in  1  slave accepts address
- slave_data_rdata_i  in  DATA_WIDTH  slave read data
- owner_o  out  NUM_PORTS  one-hot current owner, 0 in IDLE
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, owner=0, rr_ptr=NUM_PORTS-1 (so port 0 wins first), lat_cnt=0.
  - All outputs 0.
- FSM states IDLE, ADDR, RESP. owner and rr_ptr are registered.
- IDLE: if any req, pick the first requesting index scanning upward from rr_ptr+1 with wrap. Register it as owner; next state ADDR. With no request, stay in IDLE.
- ADDR:
  - slave_data_req_o = master_data_req_i[owner].
  - slave_data_addr_o = owner's address.
  - master_data_gnt_o[owner] = slave_data_gnt_i & master_data_req_i[owner]; all other gnt bits are 0.
  - Handshake (req & gnt): rr_ptr<=owner, lat_cnt<=READ_LATENCY-1, next state RESP.
  - Owner drops req before gnt: no handshake, rr_ptr unchanged, next state IDLE.
  - Slave stalls (gnt=0) with req held: stay in ADDR; address must be held stable by the master.
- RESP:
  - slave_data_req_o=0; slave_data_addr_o holds the owner address.
  - While lat_cnt!=0: decrement.
  - When lat_cnt==0: master_data_rvalid_o[owner]=1 and master_data_rdata_o[owner slice]=slave_data_rdata_i for exactly one cycle.
  - In that same cycle, arbitrate as in IDLE using the updated rr_ptr. Any request → new owner, next ADDR (back-to-back, no IDLE bubble). Otherwise next IDLE, owner<=0.
- Result: READ_LATENCY=1 gives rvalid the cycle after the handshake.
- Non-owner rdata slices and all outputs not driven above are 0. Outputs are combinational from the registered state and inputs.
- Requests from non-owners during ADDR/RESP are ignored (not queued); masters hold req until gnt.
- Only one transaction is outstanding per slave; no pipelining of a second address during RESP.
- Reset asserted mid-ADDR/RESP: immediate return to reset values; the pending response is dropped and rvalid is never issued.
- rr_ptr wraps modulo NUM_PORTS; a single requester is re-granted every transaction.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,NUM_PORTS-1,0.

Decomposition:
- Shared package (interconnect pkg):
  - Localparam helper for the owner index width, $clog2(NUM_PORTS).
  - Typedef for the FSM state enum {IDLE, ADDR, RESP}, reused by the write-side scheduler.
- One sub-module, rr_pick: combinational round-robin picker. Inputs request vector and rr_ptr; outputs one-hot grant and a found flag.
- Instantiated once; used from both IDLE and the last RESP cycle.

Test Plan:
- Single request: NUM_PORTS=2, READ_LATENCY=1, master 1 req addr 0x05A, slave gnt=1 → slave_data_req_o=1 and slave_data_addr_o=0x05A at cycle 1, master_data_gnt_o=2'b10; at cycle 2 rvalid=2'b10 and master 1 rdata=0xDEADBEEF (slave value).
- Contention: both masters req continuously, slave gnt=1 → ownership 0,1,0,1; consecutive ADDR phases 2 cycles apart, no IDLE cycles between them; each rvalid lands on the correct master with its data.
- Slave stall: slave gnt=0 for 3 cycles then 1 → state stays ADDR, req/addr stable, gnt_o=0 until the 4th ADDR cycle, then normal response.
- Withdrawn request: master 0 drops req in first ADDR cycle with gnt=0 → next state IDLE; no gnt or rvalid; next grant still starts from port 0 (rr_ptr unchanged).
- READ_LATENCY=3: handshake at cycle t → rvalid exactly at t+3, one cycle wide; slave_data_req_o low during t+1..t+3.
- Reset mid-RESP: reset=0 one cycle after handshake → all outputs 0 immediately, no rvalid after release, next arbitration grants port 0 first.
